poly_result_packer13: RTL and testbench



---
 rtl/saber_pack_pkg.sv | 36 +++
 rtl/bit_packer_52to64.sv | 58 +++++
 rtl/poly_result_packer13.sv | 131 +++++++++++++
 tb/tb_poly_result_packer13.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saber_pack_pkg.sv
// Shared constants, state encoding and lane helpers for the product result packer.
package saber_pack_pkg;

    localparam int N_COEFF    = 256;
    localparam int COEFF_W    = 13;
    localparam int WORD_W     = 64;
    localparam int LANES      = 4;
    localparam int LANE_W     = 16;
    localparam int GROUPS     = N_COEFF / LANES;
    localparam int WORDS13    = N_COEFF * COEFF_W / WORD_W;
    localparam int WORDS16    = GROUPS;
    localparam int GROUP13_W  = LANES * COEFF_W;
    localparam int PACK_BUF_W = 128;
    localparam int FILL_W     = 7;
    localparam int GRP_W      = $clog2(GROUPS);
    localparam int WCNT_W     = $clog2(WORDS16) + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MUL,
        DRAIN,
        LAST,
        FIN
    } pack_state_e;

    // Drops bits 15:13 of each lane and butts the 13-bit fields together, lane 0 lowest.
    function automatic logic [GROUP13_W-1:0] squeeze_group13(input logic [LANES*LANE_W-1:0] grp);
        logic [GROUP13_W-1:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            r[j*COEFF_W +: COEFF_W] = grp[j*LANE_W +: COEFF_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_packer_52to64.sv
// Appends IN_W-bit chunks above the current fill of a buffer and emits OUT_W-bit words LSB-first.
module bit_packer_52to64 #(
    parameter int IN_W   = 52,
    parameter int OUT_W  = 64,
    parameter int BUF_W  = 128,
    parameter int FILL_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [IN_W-1:0]   data_i,
    output logic              emit_o,
    output logic [OUT_W-1:0]  word_o,
    output logic [FILL_W-1:0] fill_o
);

    localparam logic [FILL_W-1:0] IN_F  = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] OUT_F = FILL_W'(OUT_W);

    logic [BUF_W-1:0]  buf_q, buf_d, merged;
    logic [FILL_W-1:0] fill_q, fill_d, fill_sum;

    // Fill is always below OUT_W between chunks, so at most one word leaves per chunk.
    always_comb begin
        merged   = buf_q | (BUF_W'(data_i) << fill_q);
        fill_sum = fill_q + IN_F;
        emit_o   = valid_i && !clear_i && (fill_sum >= OUT_F);
        word_o   = merged[OUT_W-1:0];
        buf_d    = buf_q;
        fill_d   = fill_q;
        if (clear_i) begin
            buf_d  = '0;
            fill_d = '0;
        end else if (valid_i) begin
            if (emit_o) begin
                buf_d  = merged >> OUT_W;
                fill_d = fill_sum - OUT_F;
            end else begin
                buf_d  = merged;
                fill_d = fill_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign fill_o = fill_q;

endmodule

// File: rtl/poly_result_packer13.sv
// Drains the multiplier accumulator four coefficients per read and writes packed words to result BRAM.
//   state    | meaning
//   IDLE     | waiting for start
//   WAIT_MUL | request latched, waiting for pol_mul_done
//   DRAIN    | read strobe high, one group per cycle for 64 cycles
//   LAST     | final registered write on the port
//   FIN      | done pulse, busy low
module poly_result_packer13
    import saber_pack_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pol_mul_done,
    input  logic              coeff16_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [WORD_W-1:0] coeff4x_in,
    output logic              read,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [WORD_W-1:0] bram_wdata,
    output logic              busy,
    output logic              done
);

    pack_state_e       state_q;
    logic              mode16_q;
    logic [ADDR_W-1:0] base_q;
    logic [GRP_W-1:0]  grp_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              busy_q;
    logic              done_q;

    logic                 pk_clear, pk_valid, pk_emit;
    logic [GROUP13_W-1:0] pk_data;
    logic [WORD_W-1:0]    pk_word;
    logic [FILL_W-1:0]    pk_fill;

    assign pk_clear = (state_q == IDLE) && start;
    assign pk_valid = (state_q == DRAIN) && !mode16_q;
    assign pk_data  = squeeze_group13(coeff4x_in);

    bit_packer_52to64 #(
        .IN_W   (GROUP13_W),
        .OUT_W  (WORD_W),
        .BUF_W  (PACK_BUF_W),
        .FILL_W (FILL_W)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (pk_clear),
        .valid_i (pk_valid),
        .data_i  (pk_data),
        .emit_o  (pk_emit),
        .word_o  (pk_word),
        .fill_o  (pk_fill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode16_q <= 1'b0;
            base_q   <= '0;
            grp_q    <= '0;
            wcnt_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode16_q <= coeff16_mode;
                        base_q   <= base_addr;
                        grp_q    <= '0;
                        wcnt_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= WAIT_MUL;
                    end
                end
                WAIT_MUL: begin
                    if (pol_mul_done) state_q <= DRAIN;
                end
                DRAIN: begin
                    // The group on coeff4x_in is consumed now; its word appears on the port next cycle.
                    if (mode16_q || pk_emit) begin
                        we_q    <= 1'b1;
                        waddr_q <= base_q + ADDR_W'(wcnt_q);
                        wdata_q <= mode16_q ? coeff4x_in : pk_word;
                        wcnt_q  <= wcnt_q + 1'b1;
                    end
                    grp_q <= grp_q + 1'b1;
                    if (grp_q == GRP_W'(GROUPS - 1)) state_q <= LAST;
                end
                LAST: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read       = (state_q == DRAIN);
    assign bram_we    = we_q;
    assign bram_waddr = waddr_q;
    assign bram_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (!rst && state_q == LAST) begin
            assert (pk_fill == '0);
            assert (wcnt_q == (mode16_q ? WCNT_W'(WORDS16) : WCNT_W'(WORDS13)));
        end
    end

endmodule

// File: tb/tb_poly_result_packer13.sv
// Self-checking bench: rotating accumulator model feeds the packer; writes are compared to a bit-stream reference.
module tb_poly_result_packer13;

    logic        clk = 1'b0;
    logic        rst, start, pol_mul_done, coeff16_mode;
    logic [7:0]  base_addr;
    logic [63:0] coeff4x_in;
    logic        read, bram_we, busy, done;
    logic [7:0]  bram_waddr;
    logic [63:0] bram_wdata;

    poly_result_packer13 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pol_mul_done (pol_mul_done),
        .coeff16_mode (coeff16_mode),
        .base_addr    (base_addr),
        .coeff4x_in   (coeff4x_in),
        .read         (read),
        .bram_we      (bram_we),
        .bram_waddr   (bram_waddr),
        .bram_wdata   (bram_wdata),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Accumulator model: 256 raw 16-bit lanes, rotated by one group per read.
    logic [15:0] acc [256];
    int rot = 0;
    always_comb coeff4x_in = {acc[4*rot+3], acc[4*rot+2], acc[4*rot+1], acc[4*rot]};
    always @(posedge clk) begin
        if (rst) rot <= 0;
        else if (read) rot <= (rot + 1) % 64;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          reads_total = 0;
    int          done_total  = 0;
    int          done_cyc    = 0;
    logic [7:0]  wr_addr [$];
    logic [63:0] wr_data [$];
    int          wr_cyc  [$];
    always @(negedge clk) begin
        if (read) reads_total++;
        if (bram_we) begin
            wr_addr.push_back(bram_waddr);
            wr_data.push_back(bram_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_total++;
            done_cyc = cyc;
        end
    end

    int passed = 0;
    int total  = 0;

    logic [7:0]  exp_addr [$];
    logic [63:0] exp_data [$];

    // Reference: 13-bit mode is coefficient i at stream bits [13i+12:13i], word w = bits [64w+63:64w].
    function automatic void build_expected(input bit m16, input logic [7:0] base);
        bit stream [256*13];
        logic [63:0] d;
        exp_addr.delete();
        exp_data.delete();
        if (m16) begin
            for (int g = 0; g < 64; g++) begin
                exp_addr.push_back(8'((int'(base) + g) % 256));
                exp_data.push_back({acc[4*g+3], acc[4*g+2], acc[4*g+1], acc[4*g]});
            end
        end else begin
            for (int i = 0; i < 256; i++)
                for (int b = 0; b < 13; b++) stream[13*i+b] = acc[i][b];
            for (int w = 0; w < 52; w++) begin
                for (int b = 0; b < 64; b++) d[b] = stream[64*w+b];
                exp_addr.push_back(8'((int'(base) + w) % 256));
                exp_data.push_back(d);
            end
        end
    endfunction

    function automatic int count_bad(input int from);
        int bad = 0;
        if (wr_addr.size() - from != exp_addr.size()) return 1000;
        for (int k = 0; k < exp_addr.size(); k++) begin
            if (wr_addr[from+k] !== exp_addr[k] || wr_data[from+k] !== exp_data[k]) begin
                if (bad == 0)
                    $display("  first bad write %0d: addr %02h data %016h, want addr %02h data %016h",
                             k, wr_addr[from+k], wr_data[from+k], exp_addr[k], exp_data[k]);
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic do_drain(input bit m16, input logic [7:0] base, output bit ok);
        int d0;
        d0 = done_total;
        coeff16_mode = m16;
        base_addr    = base;
        pol_mul_done = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400 && done_total == d0; i++) @(negedge clk);
        ok = (done_total == d0 + 1);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({read, bram_we, busy, done} !== 4'b0)
            $display("FAIL reset_ctrl: got %b want 0000", {read, bram_we, busy, done});
        else passed++;
        total++;
        if ({bram_waddr, bram_wdata} !== 72'h0)
            $display("FAIL reset_data: got addr %02h data %016h want 0", bram_waddr, bram_wdata);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp13;
        int r0, w0, bad;
        bit ok;
        bit stream [256*13];
        logic [12:0] c;
        for (int i = 0; i < 256; i++) acc[i] = 16'(i);
        build_expected(1'b0, 8'h10);
        r0 = reads_total;
        w0 = wr_addr.size();
        do_drain(1'b0, 8'h10, ok);
        total++;
        if (!ok) $display("FAIL ramp_done: no done within bound"); else passed++;
        total++;
        if (reads_total - r0 !== 64) $display("FAIL ramp_reads: got %0d want 64", reads_total - r0);
        else passed++;
        total++;
        if (wr_addr.size() - w0 !== 52) $display("FAIL ramp_nwrites: got %0d want 52", wr_addr.size() - w0);
        else passed++;
        bad = count_bad(w0);
        total++;
        if (bad !== 0) $display("FAIL ramp_words: got %0d bad writes want 0", bad); else passed++;
        if (wr_addr.size() - w0 == 52) begin
            total++;
            if (wr_data[w0] !== 64'h0040018008002000)
                $display("FAIL ramp_word0: got %016h want 0040018008002000", wr_data[w0]);
            else passed++;
            total++;
            if (wr_addr[w0] !== 8'h10 || wr_addr[w0+51] !== 8'h43)
                $display("FAIL ramp_addr_range: got %02h..%02h want 10..43", wr_addr[w0], wr_addr[w0+51]);
            else passed++;
            for (int w = 0; w < 52; w++)
                for (int b = 0; b < 64; b++) stream[64*w+b] = wr_data[w0+w][b];
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                for (int b = 0; b < 13; b++) c[b] = stream[13*i+b];
                if (int'(c) != i) bad++;
            end
            total++;
            if (bad !== 0) $display("FAIL ramp_decode: got %0d wrong coefficients want 0", bad); else passed++;
            total++;
            if (done_cyc - wr_cyc[w0+51] !== 1)
                $display("FAIL ramp_done_timing: got %0d cycles after last write want 1", done_cyc - wr_cyc[w0+51]);
            else passed++;
        end
    endtask

    task automatic test_ones_and_junk;
        int w0, bad;
        bit ok;
        for (int i = 0; i < 256; i++) acc[i] = 16'hFFFF;
        w0 = wr_addr.size();
        do_drain(1'b0, 8'h00, ok);
        bad = (wr_addr.size() - w0 == 52) ? 0 : 1000;
        for (int k = w0; k < wr_addr.size(); k++) if (wr_data[k] !== 64'hFFFF_FFFF_FFFF_FFFF) bad++;
        total++;
        if (!ok || bad !== 0) $display("FAIL ones_words: got %0d bad (done %0b) want 0", bad, ok); else passed++;

        for (int i = 0; i < 256; i++) acc[i] = 16'hE000;
        w0 = wr_addr.size();
        do_drain(1'b0, 8'h80, ok);
        bad = (wr_addr.size() - w0 == 52) ? 0 : 1000;
        for (int k = w0; k < wr_addr.size(); k++) if (wr_data[k] !== 64'h0) bad++;
        total++;
        if (!ok || bad !== 0) $display("FAIL junk_dropped: got %0d bad (done %0b) want 0", bad, ok); else passed++;
    endtask

    task automatic test_mode16_wrap;
        int w0, bad;
        bit ok;
        for (int i = 0; i < 256; i++) acc[i] = 16'(i);
        build_expected(1'b1, 8'hF0);
        w0 = wr_addr.size();
        do_drain(1'b1, 8'hF0, ok);
        total++;
        if (!ok || wr_addr.size() - w0 !== 64)
            $display("FAIL m16_nwrites: got %0d (done %0b) want 64", wr_addr.size() - w0, ok);
        else passed++;
        bad = count_bad(w0);
        total++;
        if (bad !== 0) $display("FAIL m16_words: got %0d bad writes want 0", bad); else passed++;
        if (wr_addr.size() - w0 == 64) begin
            total++;
            if (wr_addr[w0+15] !== 8'hFF || wr_addr[w0+16] !== 8'h00)
                $display("FAIL m16_wrap: got %02h->%02h want ff->00", wr_addr[w0+15], wr_addr[w0+16]);
            else passed++;
            total++;
            if (done_cyc - wr_cyc[w0+63] !== 1)
                $display("FAIL m16_done_timing: got %0d want 1", done_cyc - wr_cyc[w0+63]);
            else passed++;
        end
    endtask

    task automatic test_random;
        int w0, bad;
        bit ok, m16;
        logic [7:0] base;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 256; i++) acc[i] = 16'($urandom);
            m16  = (it % 2 == 1);
            base = 8'($urandom);
            build_expected(m16, base);
            w0 = wr_addr.size();
            do_drain(m16, base, ok);
            bad = count_bad(w0);
            total++;
            if (!ok || bad !== 0)
                $display("FAIL random_%0d: mode16 %0b base %02h got %0d bad (done %0b) want 0", it, m16, base, bad, ok);
            else passed++;
        end
    endtask

    task automatic test_late_done_and_restart;
        int r0, d0, w0, early, bad;
        for (int i = 0; i < 256; i++) acc[i] = 16'($urandom);
        build_expected(1'b0, 8'h33);
        r0 = reads_total;
        d0 = done_total;
        w0 = wr_addr.size();
        pol_mul_done = 1'b0;
        coeff16_mode = 1'b0;
        base_addr    = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        early = reads_total - r0;
        total++;
        if (early !== 0 || busy !== 1'b1)
            $display("FAIL late_wait: got %0d reads busy %0b want 0 reads busy 1", early, busy);
        else passed++;
        pol_mul_done = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b1;
        pol_mul_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && done_total == d0; i++) @(negedge clk);
        repeat (80) @(negedge clk);
        total++;
        if (reads_total - r0 !== 64 || done_total - d0 !== 1)
            $display("FAIL late_single_drain: got %0d reads %0d dones want 64 reads 1 done",
                     reads_total - r0, done_total - d0);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL late_not_queued: got busy %0b want 0", busy); else passed++;
        bad = count_bad(w0);
        total++;
        if (bad !== 0) $display("FAIL late_words: got %0d bad writes want 0", bad); else passed++;
        pol_mul_done = 1'b1;
    endtask

    task automatic test_reset_mid_drain;
        int r0, d0, w0, bad;
        bit ok;
        for (int i = 0; i < 256; i++) acc[i] = 16'($urandom);
        r0 = reads_total;
        d0 = done_total;
        coeff16_mode = 1'b0;
        base_addr    = 8'h20;
        pol_mul_done = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && reads_total - r0 < 30; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({read, bram_we, busy} !== 3'b000)
            $display("FAIL rst_abort: got read/we/busy %b want 000", {read, bram_we, busy});
        else passed++;
        rst = 1'b0;
        w0 = wr_addr.size();
        repeat (100) @(negedge clk);
        total++;
        if (done_total !== d0 || wr_addr.size() !== w0)
            $display("FAIL rst_no_done: got %0d dones %0d writes want 0 and 0", done_total - d0, wr_addr.size() - w0);
        else passed++;
        build_expected(1'b0, 8'h20);
        do_drain(1'b0, 8'h20, ok);
        bad = count_bad(w0);
        total++;
        if (!ok || bad !== 0) $display("FAIL rst_restart: got %0d bad (done %0b) want 0", bad, ok); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pol_mul_done = 1'b0;
        coeff16_mode = 1'b0;
        base_addr = 8'h00;
        for (int i = 0; i < 256; i++) acc[i] = 16'h0;
        @(negedge clk);
        test_reset();
        test_ramp13();
        test_ones_and_junk();
        test_mode16_wrap();
        test_random();
        test_late_done_and_restart();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
